z2_bus_tracker: RTL and testbench
=================================

Name: z2_bus_tracker

Overview:
- Zorro II slave-side cycle tracker. Sits directly upstream of the SDRAM controller.
- Synchronises AS_n/UDS_n/LDS_n into CLK and decodes the autoconfigured RAM window. Produces the z2_state and RAM_CYCLE inputs the SDRAM controller consumes.
- Takes the controller's dtack back and turns it into the bus-side DTACK output enable and the data-buffer controls.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on AS_n, UDS_n, LDS_n and RW (minimum 2).

Ports:
- CLK  in  1  system clock, same clock as the SDRAM controller.
- RESET  in  1  synchronous, active-high reset.
- AS_n  in  1  Zorro II address strobe, asynchronous.
- UDS_n  in  1  upper data strobe, asynchronous.
- LDS_n  in  1  lower data strobe, asynchronous.
- RW  in  1  bus read/write (1 = read), asynchronous.
- ADDR  in  3  bus address bits [23:21].
- ram_base  in  3  autoconfig base address bits [23:21].
- ram_size  in  2  window size: 00 = 2MB, 01 = 4MB, 10 = 8MB, 11 = disabled.
- ram_configured  in  1  autoconfig complete.
- dtack  in  1  acknowledge from the SDRAM controller.
- z2_state  out  2  IDLE=0, START=1, DATA=2, END=3.
- RAM_CYCLE  out  1  current bus cycle targets this card's RAM.
- DTACK_OE  out  1  drive DTACK_n low on the bus (open-drain enable).
- DBOE_n  out  1  data buffer output enable, active low.
- DBDIR  out  1  data buffer direction; 1 = card drives the bus (read).

Behaviour:
- Reset: one clock, synchronous, active-high. At the edge where RESET=1, all of the following take effect:
  - z2_state=IDLE, RAM_CYCLE=0, DTACK_OE=0, DBOE_n=1, DBDIR=0.
  - All synchroniser flops load 1 (strobes negated, RW=read).
  - armed=0.
- Synchronisers: as_s, ds_s = !(uds_s & lds_s), rw_s are the last-stage outputs. A strobe asserted before edge k is first visible as as_s=0 after edge k+SYNC_STAGES-1.
- armed is set when as_s=1 is sampled. No cycle may start while armed=0. This prevents adopting a cycle already in flight when reset is released.
- Window match (combinational), with ram_configured=1 required in every case:
  - 2MB: ADDR[23:21]==ram_base[23:21].
  - 4MB: ADDR[23:22]==ram_base[23:22].
  - 8MB: ADDR[23]==ram_base[23].
  - ram_size=11: never matches.
- State machine (one transition per edge):
  - IDLE: if armed & !as_s, go to START. RAM_CYCLE <= match, DBDIR <= rw_s & match. Otherwise stay.
  - START: if as_s, the cycle was aborted: go to IDLE and clear RAM_CYCLE. Else if ds_s, go to DATA. Else stay.
  - DATA: if as_s, go to END. Else stay. There is no timeout; DMA and slow masters may stretch the cycle indefinitely.
  - END: go to IDLE unconditionally. RAM_CYCLE <= 0, DBDIR <= 0.
- z2_state tracks every bus cycle, including non-matching ones. RAM_CYCLE qualifies which cycles belong to this card. ADDR is only sampled on the IDLE->START edge.
- DTACK_OE (registered) <= RAM_CYCLE & dtack & (z2_state==START or DATA). It falls on the edge that enters END, or on the edge after dtack drops, whichever comes first. It must never be 1 while RAM_CYCLE=0.
- DBOE_n (registered) <= !(RAM_CYCLE & z2_state==DATA & !as_s). It returns to 1 on the same edge that leaves DATA.
- Simultaneous AS and DS negation in DATA: DATA->END. A new AS assertion while in END is picked up from IDLE on the following edge, so a back-to-back cycle costs one IDLE cycle minimum.
- Strobe glitch in START: ds_s asserting and as_s negating on the same edge resolves as an abort (as_s has priority).
- RESET asserted mid-cycle: all outputs return to reset values on that edge. Tracking resumes only after AS_n has been seen negated.

Decomposition:
- Shared package/header (globalparams): Z2_IDLE/Z2_START/Z2_DATA/Z2_END encodings and the ram_size encodings. The SDRAM controller consumes the same state constants.
- One natural sub-module: z2_sync, a parameterised SYNC_STAGES-deep synchroniser with a synchronous reset value of 1. Instantiated once per strobe, plus once for RW.

Test Plan:
- Read hit: ram_configured=1, ram_size=00, ram_base=3'b001, ADDR=3'b001, RW=1; AS_n low, then UDS_n/LDS_n low; dtack driven high in START. Expected:
  - z2_state goes IDLE->START->DATA, then END->IDLE after AS_n rises.
  - RAM_CYCLE=1 from START until END, and DBDIR=1 over the same span.
  - DTACK_OE=1 from the edge after dtack rises until END.
  - DBOE_n=0 only in DATA.
- Miss: as the read hit but ADDR=3'b010. Expected: z2_state still cycles IDLE->START->DATA->END->IDLE; RAM_CYCLE, DTACK_OE and DBDIR stay 0; DBOE_n stays 1.
- Size masking: ram_size=10, ram_base=3'b100, ADDR=3'b111 gives RAM_CYCLE=1. ram_size=11 with the same address gives RAM_CYCLE=0.
- Abort: AS_n pulses low for SYNC_STAGES+2 clocks with no DS. Expected: START->IDLE, RAM_CYCLE cleared, DTACK_OE never asserted.
- Reset mid-cycle: RESET for 1 clock while in DATA with AS_n held low. Expected: all outputs take reset values on the next edge, and z2_state stays IDLE until AS_n goes high and then low again.
- Back-to-back: AS_n rises for exactly 1 CLK between two hits. Expected: END, IDLE, START sequence with no missed cycle, and RAM_CYCLE re-latched from the new ADDR.

Source files
------------

// File: rtl/z2_bus_tracker_pkg.sv
// Shared Zorro II cycle-state encodings and RAM window decode, also consumed
// by the SDRAM controller.
package z2_bus_tracker_pkg;

    typedef enum logic [1:0] {
        Z2_IDLE  = 2'd0,
        Z2_START = 2'd1,
        Z2_DATA  = 2'd2,
        Z2_END   = 2'd3
    } z2_state_t;

    localparam logic [1:0] RAM_SIZE_2MB = 2'b00;
    localparam logic [1:0] RAM_SIZE_4MB = 2'b01;
    localparam logic [1:0] RAM_SIZE_8MB = 2'b10;
    localparam logic [1:0] RAM_SIZE_OFF = 2'b11;

    // Address bits [23:21] against the autoconfig base, masked by window size.
    function automatic logic ram_match(input logic [2:0] addr,
                                       input logic [2:0] base,
                                       input logic [1:0] size,
                                       input logic       configured);
        logic hit;
        case (size)
            RAM_SIZE_2MB: hit = (addr == base);
            RAM_SIZE_4MB: hit = (addr[2:1] == base[2:1]);
            RAM_SIZE_8MB: hit = (addr[2] == base[2]);
            default:      hit = 1'b0;
        endcase
        return configured & hit;
    endfunction

endpackage

// File: rtl/z2_sync.sv
// Multi-flop synchroniser for an asynchronous bus signal; resets to 1 so
// strobes read as negated and RW reads as "read" straight out of reset.
module z2_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/z2_bus_tracker.sv
// Zorro II slave-side cycle tracker: follows AS/DS through each bus cycle,
// flags cycles hitting our RAM window and drives DTACK and the data buffers.
module z2_bus_tracker
    import z2_bus_tracker_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AS_n,
    input  logic       UDS_n,
    input  logic       LDS_n,
    input  logic       RW,
    input  logic [2:0] ADDR,
    input  logic [2:0] ram_base,
    input  logic [1:0] ram_size,
    input  logic       ram_configured,
    input  logic       dtack,
    output logic [1:0] z2_state,
    output logic       RAM_CYCLE,
    output logic       DTACK_OE,
    output logic       DBOE_n,
    output logic       DBDIR
);

    logic as_s, uds_s, lds_s, rw_s, ds_s;

    z2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_as  (.CLK(CLK), .RESET(RESET), .d(AS_n),  .q(as_s));
    z2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uds (.CLK(CLK), .RESET(RESET), .d(UDS_n), .q(uds_s));
    z2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lds (.CLK(CLK), .RESET(RESET), .d(LDS_n), .q(lds_s));
    z2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rw  (.CLK(CLK), .RESET(RESET), .d(RW),    .q(rw_s));

    assign ds_s = ~(uds_s & lds_s);

    // The synchroniser's reset-loaded 1s are not a real sample of AS_n, so
    // armed only trusts as_s once every stage has been refilled from the pin.
    logic [SYNC_STAGES-1:0] primed;
    logic                   armed;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            primed <= '0;
            armed  <= 1'b0;
        end else begin
            primed <= {primed[SYNC_STAGES-2:0], 1'b1};
            if (as_s && primed[SYNC_STAGES-1]) begin
                armed <= 1'b1;
            end
        end
    end

    z2_state_t state, state_nxt;
    logic      match;
    logic      ram_cycle_nxt, dbdir_nxt, dtack_oe_nxt, dboe_n_nxt;
    logic      active_now, active_nxt;

    assign match    = ram_match(ADDR, ram_base, ram_size, ram_configured);
    assign z2_state = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= Z2_IDLE;
            RAM_CYCLE <= 1'b0;
            DTACK_OE  <= 1'b0;
            DBOE_n    <= 1'b1;
            DBDIR     <= 1'b0;
        end else begin
            state     <= state_nxt;
            RAM_CYCLE <= ram_cycle_nxt;
            DTACK_OE  <= dtack_oe_nxt;
            DBOE_n    <= dboe_n_nxt;
            DBDIR     <= dbdir_nxt;
        end
    end

    // No timeout in DATA: slow masters and DMA may hold AS for as long as they like.
    always_comb begin
        state_nxt = state;
        case (state)
            Z2_IDLE:  if (armed && !as_s) state_nxt = Z2_START;
            Z2_START: begin
                if (as_s)      state_nxt = Z2_IDLE;
                else if (ds_s) state_nxt = Z2_DATA;
            end
            Z2_DATA:  if (as_s) state_nxt = Z2_END;
            Z2_END:   state_nxt = Z2_IDLE;
            default:  state_nxt = Z2_IDLE;
        endcase
    end

    // dtack/DTACK_OE handshake: the controller raises dtack while it owns a
    // RAM cycle; DTACK_OE follows one edge later and drops on the edge that
    // leaves START/DATA or the edge after dtack falls, and never without RAM_CYCLE.
    always_comb begin
        ram_cycle_nxt = RAM_CYCLE;
        dbdir_nxt     = DBDIR;
        case (state)
            Z2_IDLE: begin
                if (state_nxt == Z2_START) begin
                    ram_cycle_nxt = match;
                    dbdir_nxt     = rw_s & match;
                end
            end
            Z2_START: begin
                if (state_nxt == Z2_IDLE) begin
                    ram_cycle_nxt = 1'b0;
                    dbdir_nxt     = 1'b0;
                end
            end
            Z2_END: begin
                ram_cycle_nxt = 1'b0;
                dbdir_nxt     = 1'b0;
            end
            default: ;
        endcase

        active_now   = (state == Z2_START) || (state == Z2_DATA);
        active_nxt   = (state_nxt == Z2_START) || (state_nxt == Z2_DATA);
        dtack_oe_nxt = RAM_CYCLE & dtack & active_now & active_nxt;
        dboe_n_nxt   = ~(RAM_CYCLE & (state == Z2_DATA) & ~as_s);
    end

endmodule

// File: tb/tb_z2_bus_tracker.sv
// Directed bench for z2_bus_tracker: hand-traced bus cycles with the
// expected outputs checked after each relevant clock edge.
module tb_z2_bus_tracker;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_END   = 2'd3;

    logic       CLK;
    logic       RESET;
    logic       AS_n, UDS_n, LDS_n, RW;
    logic [2:0] ADDR, ram_base;
    logic [1:0] ram_size;
    logic       ram_configured, dtack;
    logic [1:0] z2_state;
    logic       RAM_CYCLE, DTACK_OE, DBOE_n, DBDIR;

    int total = 0;
    int bad   = 0;

    z2_bus_tracker #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
        .ADDR(ADDR), .ram_base(ram_base), .ram_size(ram_size),
        .ram_configured(ram_configured), .dtack(dtack),
        .z2_state(z2_state), .RAM_CYCLE(RAM_CYCLE), .DTACK_OE(DTACK_OE),
        .DBOE_n(DBOE_n), .DBDIR(DBDIR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] st, input logic rc,
                       input logic oe, input logic dboe, input logic dir);
        total++;
        assert (z2_state === st) else begin
            bad++;
            $error("FAIL %s z2_state got=%0d exp=%0d", tag, z2_state, st);
        end
        total++;
        assert (RAM_CYCLE === rc) else begin
            bad++;
            $error("FAIL %s RAM_CYCLE got=%b exp=%b", tag, RAM_CYCLE, rc);
        end
        total++;
        assert (DTACK_OE === oe) else begin
            bad++;
            $error("FAIL %s DTACK_OE got=%b exp=%b", tag, DTACK_OE, oe);
        end
        total++;
        assert (DBOE_n === dboe) else begin
            bad++;
            $error("FAIL %s DBOE_n got=%b exp=%b", tag, DBOE_n, dboe);
        end
        total++;
        assert (DBDIR === dir) else begin
            bad++;
            $error("FAIL %s DBDIR got=%b exp=%b", tag, DBDIR, dir);
        end
    endtask

    initial begin
        RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
        ADDR = 3'b001; ram_base = 3'b001; ram_size = 2'b00;
        ram_configured = 1'b1; dtack = 1'b0;
        tick(1);
        RESET = 1'b0;
        chk("reset", S_IDLE, 0, 0, 1, 0);
        tick(4);
        chk("idle_armed", S_IDLE, 0, 0, 1, 0);

        // Read hit
        AS_n = 1'b0;
        tick(2); chk("hit_sync_lag", S_IDLE, 0, 0, 1, 0);
        tick(1); chk("hit_start", S_START, 1, 0, 1, 1);
        UDS_n = 1'b0; LDS_n = 1'b0; dtack = 1'b1;
        tick(1); chk("hit_dtack_oe", S_START, 1, 1, 1, 1);
        tick(2); chk("hit_data", S_DATA, 1, 1, 1, 1);
        tick(1); chk("hit_dboe", S_DATA, 1, 1, 0, 1);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(2); chk("hit_data_hold", S_DATA, 1, 1, 0, 1);
        tick(1); chk("hit_end", S_END, 1, 0, 1, 1);
        dtack = 1'b0;
        tick(1); chk("hit_idle", S_IDLE, 0, 0, 1, 0);

        // Miss: full cycle tracked, nothing driven
        ADDR = 3'b010; dtack = 1'b1; AS_n = 1'b0;
        tick(3); chk("miss_start", S_START, 0, 0, 1, 0);
        UDS_n = 1'b0; LDS_n = 1'b0;
        tick(4); chk("miss_data", S_DATA, 0, 0, 1, 0);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(3); chk("miss_end", S_END, 0, 0, 1, 0);
        tick(1); chk("miss_idle", S_IDLE, 0, 0, 1, 0);
        dtack = 1'b0;

        // Back-to-back: miss cycle, AS_n high one clock, then a hit
        AS_n = 1'b0;
        tick(3); chk("b2b_start1", S_START, 0, 0, 1, 0);
        UDS_n = 1'b0; LDS_n = 1'b0;
        tick(3); chk("b2b_data1", S_DATA, 0, 0, 1, 0);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(1);
        AS_n = 1'b0; ADDR = 3'b001;
        tick(2); chk("b2b_end", S_END, 0, 0, 1, 0);
        tick(1); chk("b2b_idle", S_IDLE, 0, 0, 1, 0);
        tick(1); chk("b2b_start2", S_START, 1, 0, 1, 1);
        AS_n = 1'b1;
        tick(3); chk("b2b_abort", S_IDLE, 0, 0, 1, 0);

        // Size masking: 8MB hit on a write, disabled window, unconfigured, 4MB
        ram_size = 2'b10; ram_base = 3'b100; ADDR = 3'b111; RW = 1'b0;
        AS_n = 1'b0;
        tick(3); chk("size8_hit", S_START, 1, 0, 1, 0);
        AS_n = 1'b1; tick(3);
        ram_size = 2'b11; RW = 1'b1; AS_n = 1'b0;
        tick(3); chk("size_off", S_START, 0, 0, 1, 0);
        AS_n = 1'b1; tick(3);
        ram_size = 2'b00; ram_base = 3'b111; ram_configured = 1'b0; AS_n = 1'b0;
        tick(3); chk("unconfigured", S_START, 0, 0, 1, 0);
        AS_n = 1'b1; tick(3);
        ram_configured = 1'b1; ram_size = 2'b01; ram_base = 3'b010; ADDR = 3'b011;
        AS_n = 1'b0;
        tick(3); chk("size4_hit", S_START, 1, 0, 1, 1);
        AS_n = 1'b1; tick(3);
        ram_size = 2'b00; ram_base = 3'b001; ADDR = 3'b001;

        // Abort: AS_n low for four clocks, no DS
        AS_n = 1'b0;
        tick(3); chk("abort_start", S_START, 1, 0, 1, 1);
        tick(1);
        AS_n = 1'b1;
        tick(2); chk("abort_hold", S_START, 1, 0, 1, 1);
        tick(1); chk("abort_idle", S_IDLE, 0, 0, 1, 0);

        // DS asserting and AS negating on the same edge resolves as abort
        AS_n = 1'b0;
        tick(3); chk("glitch_start", S_START, 1, 0, 1, 1);
        UDS_n = 1'b0; LDS_n = 1'b0; AS_n = 1'b1;
        tick(2); chk("glitch_hold", S_START, 1, 0, 1, 1);
        tick(1); chk("glitch_abort", S_IDLE, 0, 0, 1, 0);
        UDS_n = 1'b1; LDS_n = 1'b1;
        tick(2);

        // Reset in DATA with AS_n held low
        AS_n = 1'b0;
        tick(3);
        UDS_n = 1'b0; LDS_n = 1'b0; dtack = 1'b1;
        tick(4); chk("rst_pre_data", S_DATA, 1, 1, 0, 1);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        chk("rst_mid", S_IDLE, 0, 0, 1, 0);
        dtack = 1'b0;
        tick(6); chk("rst_no_adopt", S_IDLE, 0, 0, 1, 0);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        tick(4);
        AS_n = 1'b0;
        tick(3); chk("rst_resume", S_START, 1, 0, 1, 1);
        AS_n = 1'b1;
        tick(3); chk("rst_final_idle", S_IDLE, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
